// File: rtl/demo_pkg.sv
// Shared types and constants for the demo song recorder.
// Voice word layout (16 bits, MSB first): pitch[11:0], vol[1:0], wave[1:0].
package demo_pkg;

    localparam int DEMO_NUM_CH  = 25;
    localparam int DEMO_PITCH_W = 12;
    localparam int DEMO_VOICES  = 6;
    localparam int DEMO_WORD_W  = 96;

    typedef struct packed {
        logic [11:0] pitch;
        logic [1:0]  vol;
        logic [1:0]  wave;
    } demo_voice_t;

    typedef enum logic [1:0] {
        IDLE,
        RECORD,
        DONE
    } demo_enc_state_t;

    // Collapse a 4-channel enable group into a 2-bit volume code.
    // Bit 2 of the group never influences the code.
    function automatic logic [1:0] encode_vol(input logic [3:0] ena);
        logic [1:0] code;
        if (ena[3])      code = 2'd3;
        else if (ena[1]) code = 2'd2;
        else if (ena[0]) code = 2'd1;
        else             code = 2'd0;
        return code;
    endfunction

endpackage

// File: rtl/demo_tick_gen.sv
// Tempo tick generator: free-running 0..DIV-1 counter with synchronous
// clear and enable; tick is high in the cycle the enabled counter sits at 0.
module demo_tick_gen #(
    parameter int  DIV = 100,
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear wins, then wrap at DIV-1 while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + CW'(1);
    end

    // Counter register, async active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign tick = en && !clr && (cnt_q == '0);

endmodule

// File: rtl/demo_encoder.sv
// Demo song recorder: once per tempo tick, packs six voices (channels
// 0,4,...,20) of the live channel bus into a 96-bit word and issues a
// single-cycle memory write. Channel 24 and non-base channels are ignored.
// Build option DEMO_ENCODER_LOOP_EN: wrap the address and keep recording
// until stop, with rec_length saturating at DEMO_SONG_LENGTH.
module demo_encoder
    import demo_pkg::*;
#(
    parameter int  DEMO_SONG_LENGTH = 128,
    parameter int  DEMO_CLK_DIVIDE  = 100,
    localparam int AW = $clog2(DEMO_SONG_LENGTH),
    localparam int LW = AW + 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                stop,
    input  logic [DEMO_NUM_CH*DEMO_PITCH_W-1:0] live_pitches,
    input  logic [DEMO_NUM_CH-1:0]              live_channel_ena,
    input  logic [DEMO_NUM_CH*2-1:0]            live_waveforms,
    output logic                                wr_en,
    output logic [AW-1:0]                       wr_addr,
    output logic [DEMO_WORD_W-1:0]              wr_data,
    output logic                                busy,
    output logic                                done,
    output logic [LW-1:0]                       rec_length
);

    localparam int            C         = DEMO_PITCH_W;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEMO_SONG_LENGTH - 1);
    localparam logic [LW-1:0] FULL_LEN  = LW'(DEMO_SONG_LENGTH);

    demo_enc_state_t        state_q, state_d;
    logic [AW-1:0]          ptr_q, ptr_d;
    logic                   wr_en_q, wr_en_d;
    logic [AW-1:0]          wr_addr_q, wr_addr_d;
    logic [DEMO_WORD_W-1:0] wr_data_q, wr_data_d;
    logic [LW-1:0]          rec_len_q, rec_len_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   tick;
    logic                   tick_en;
    logic [DEMO_WORD_W-1:0] enc_word;
    logic                   unused_inputs;

    // Only the voice base channels feed the word; keep the rest visibly consumed.
    assign unused_inputs = ^{live_pitches, live_channel_ena, live_waveforms};

    // Counter runs only in RECORD and sits at 0 otherwise, so the first
    // RECORD cycle is a sample cycle.
    assign tick_en = (state_q == RECORD);

    demo_tick_gen #(.DIV(DEMO_CLK_DIVIDE)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (!tick_en),
        .en   (tick_en),
        .tick (tick)
    );

    // Voice k takes base channel 4*(5-k): voice 0 (LSBs) is channel 20.
    for (genvar k = 0; k < DEMO_VOICES; k++) begin : g_voice
        localparam int B = 4 * (DEMO_VOICES - 1 - k);
        demo_voice_t v;
        assign v.pitch = live_pitches[C*B +: C];
        assign v.vol   = encode_vol(live_channel_ena[B +: 4]);
        assign v.wave  = live_waveforms[2*B +: 2];
        assign enc_word[16*k +: 16] = v;
    end

    // FSM next state and write-pipeline update; stop beats a same-cycle sample.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rec_len_d = rec_len_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RECORD;
                    ptr_d     = '0;
                    wr_addr_d = '0;
                    rec_len_d = '0;
                end
            end
            RECORD: begin
                if (stop) begin
                    state_d = DONE;
                end else if (tick) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_data_d = enc_word;
`ifdef DEMO_ENCODER_LOOP_EN
                    ptr_d = (ptr_q == LAST_ADDR) ? '0 : ptr_q + AW'(1);
                    if (rec_len_q != FULL_LEN)
                        rec_len_d = rec_len_q + LW'(1);
`else
                    rec_len_d = rec_len_q + LW'(1);
                    if (ptr_q == LAST_ADDR)
                        state_d = DONE;
                    else
                        ptr_d = ptr_q + AW'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RECORD);
        done_d = (state_d == DONE);
    end

    // State and registered outputs, async active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rec_len_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rec_len_q <= rec_len_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign rec_length = rec_len_q;

endmodule

// File: tb/tb_demo_encoder.sv
// Scoreboard bench for demo_encoder (DEMO_CLK_DIVIDE=4, DEMO_SONG_LENGTH=8).
module tb_demo_encoder;

    localparam int L   = 8;
    localparam int DIV = 4;
    localparam int AW  = 3;
    localparam int LW  = 4;

    // ch20 ABC/wave2/ena1111 -> ABCE ; ch0 123/wave1/ena0011 -> 1239
    localparam logic [95:0] WORD_A = 96'h1239_0000_0000_0000_0000_ABCE;
    // vol codes: ch0 grp 0011->2, ch4 0001->1, ch8 0101->1, ch12 0110->2,
    // ch16 1000->3, ch20 0000->0 (vol sits at bits 3:2 of each voice)
    localparam logic [95:0] WORD_B = 96'h0008_0004_0004_0008_000C_0000;

    logic          clk, rst, start, stop;
    logic [299:0]  lp;
    logic [24:0]   le;
    logic [49:0]   lw;
    logic          wr_en, busy, done;
    logic [AW-1:0] wr_addr;
    logic [95:0]   wr_data;
    logic [LW-1:0] rec_length;

    typedef struct {
        int          addr;
        logic [95:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0, failures = 0;
    int   nwr = 0, ncyc = 0, mark = 0, prev = 0;
    bit   expect_first = 0;

    demo_encoder #(.DEMO_SONG_LENGTH(L), .DEMO_CLK_DIVIDE(DIV)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .stop             (stop),
        .live_pitches     (lp),
        .live_channel_ena (le),
        .live_waveforms   (lw),
        .wr_en            (wr_en),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .busy             (busy),
        .done             (done),
        .rec_length       (rec_length)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chkw(input string name, input logic [95:0] act, input logic [95:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic chki(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Monitor: pop and compare on every write; also check latency/spacing.
    always @(negedge clk) begin
        exp_t e;
        ncyc = ncyc + 1;
        if (rst === 1'b1 && wr_en === 1'b1) begin
            nwr = nwr + 1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: addr %0d data %h, none expected", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                chki("wr_addr", int'(wr_addr), e.addr);
                chkw("wr_data", wr_data, e.data);
            end
            if (expect_first) begin
                chki("first_write_latency", ncyc - mark, 3);
                expect_first = 0;
            end else begin
                chki("write_spacing", ncyc - prev, DIV);
            end
            prev = ncyc;
        end
    end

    task automatic push(input int addr, input logic [95:0] data);
        exp_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start(input bit with_stop);
        @(posedge clk); #1;
        start = 1'b1;
        stop  = with_stop;
        mark  = ncyc;
        expect_first = 1;
        @(posedge clk); #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int bound);
        int k;
        k = 0;
        while (nwr < n && k < bound) begin
            @(negedge clk); #1;
            k++;
        end
        chki("write_arrived", nwr >= n ? 1 : 0, 1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
        chki("no_pending_writes", exp_q.size(), 0);
    endtask

    task automatic set_a();
        lp = '0; lw = '0;
        lp[12*20 +: 12] = 12'hABC; lw[2*20 +: 2] = 2'd2;
        lp[0 +: 12]     = 12'h123; lw[0 +: 2]    = 2'd1;
        lp[12*24 +: 12] = 12'hFFF; lw[2*24 +: 2] = 2'd3;   // ignored channel
        lp[12*5 +: 12]  = 12'h777; lw[2*5 +: 2]  = 2'd3;   // non-base channel
        le = 25'h1F00003;
    endtask

    task automatic set_b();
        lp = '0; lw = '0;
        le = 25'h0086513;
    endtask

    task automatic chk_outputs_zero();
        chki("rst_wr_en", int'(wr_en), 0);
        chki("rst_wr_addr", int'(wr_addr), 0);
        chkw("rst_wr_data", wr_data, 96'h0);
        chki("rst_busy", int'(busy), 0);
        chki("rst_done", int'(done), 0);
        chki("rst_rec_length", int'(rec_length), 0);
    endtask

    initial begin
        int base;
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        lp = '0; le = '0; lw = '0;
        #12;
        chk_outputs_zero();
        @(posedge clk); #1 rst = 1'b1;

        // Encode check, one word then stop.
        base = nwr;
        set_a();
        push(0, WORD_A);
        pulse_start(0);
        wait_writes(base + 1, 20);
        chki("busy_in_record", int'(busy), 1);
        pulse_stop();
        chki("t1_done", int'(done), 1);
        chki("t1_busy", int'(busy), 0);
        chki("t1_rec_length", int'(rec_length), 1);

        // Volume priority codes.
        base = nwr;
        set_b();
        push(0, WORD_B);
        pulse_start(0);
        wait_writes(base + 1, 20);
        pulse_stop();
        chki("t2_rec_length", int'(rec_length), 1);

        // Full take; ch24 toggles after every write and must not matter.
        base = nwr;
        set_a();
`ifdef DEMO_ENCODER_LOOP_EN
        for (int i = 0; i < 10; i++) push(i % L, WORD_A);
        pulse_start(0);
        for (int i = 1; i <= 10; i++) begin
            wait_writes(base + i, 20);
            lp[12*24 +: 12] = ~lp[12*24 +: 12];
            le[24] = ~le[24];
            lw[48 +: 2] = ~lw[48 +: 2];
        end
        pulse_stop();
        chki("loop_done", int'(done), 1);
        chki("loop_busy", int'(busy), 0);
        chki("loop_rec_length", int'(rec_length), L);
        idle_cycles(12);
`else
        for (int i = 0; i < L; i++) push(i, WORD_A);
        pulse_start(0);
        for (int i = 1; i <= L; i++) begin
            wait_writes(base + i, 20);
            lp[12*24 +: 12] = ~lp[12*24 +: 12];
            le[24] = ~le[24];
            lw[48 +: 2] = ~lw[48 +: 2];
        end
        chki("full_done", int'(done), 1);
        chki("full_busy", int'(busy), 0);
        chki("full_rec_length", int'(rec_length), L);
        chki("full_wr_addr_hold", int'(wr_addr), L - 1);
        idle_cycles(12);
        chki("full_done_held", int'(done), 1);
`endif

        // Early stop after the third write.
        base = nwr;
        set_a();
        for (int i = 0; i < 3; i++) push(i, WORD_A);
        pulse_start(0);
        wait_writes(base + 3, 40);
        pulse_stop();
        chki("early_done", int'(done), 1);
        chki("early_rec_length", int'(rec_length), 3);
        idle_cycles(10);

        // Stop in the same cycle as the second sample: no second write.
        base = nwr;
        push(0, WORD_A);
        pulse_start(0);
        wait_writes(base + 1, 20);
        repeat (3) @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        chki("coinc_done", int'(done), 1);
        chki("coinc_rec_length", int'(rec_length), 1);
        idle_cycles(10);

        // Reset mid-recording, then start+stop together from IDLE.
        base = nwr;
        push(0, WORD_A);
        pulse_start(0);
        wait_writes(base + 1, 20);
        @(posedge clk); #1 rst = 1'b0;
        #1 chk_outputs_zero();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        idle_cycles(10);
        chki("idle_after_rst_busy", int'(busy), 0);
        chki("idle_after_rst_done", int'(done), 0);

        base = nwr;
        push(0, WORD_A);
        pulse_start(1);
        wait_writes(base + 1, 20);
        chki("start_wins_busy", int'(busy), 1);
        pulse_stop();
        chki("start_wins_done", int'(done), 1);
        chki("start_wins_rec_length", int'(rec_length), 1);
        idle_cycles(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demo_encoder.md
Name: demo_encoder

Overview:
- Records live synth channel state into demo ROM/RAM words: the writer counterpart to the demo playback decoder.
- Once per tempo tick it encodes the 25-channel pitch/enable/waveform bus into one 96-bit word (6 voices × 16 bits) and issues a single-cycle write to block RAM.
- Sits between the channel-control bus and the demo song memory.

Parameters:
- DEMO_SONG_LENGTH, 128, number of words per recording; address width is $clog2(DEMO_SONG_LENGTH).
- DEMO_CLK_DIVIDE, 100, clk cycles per tempo tick; must be ≥ 2.
- NUM, 25, channel count; fixed, not to be overridden.
- C, 12, pitch width per channel; fixed.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin recording (level-sampled)
- stop  in  1  end recording early
- live_pitches  in  NUM*C  channel n pitch at [12n+11:12n]
- live_channel_ena  in  NUM  channel n enable at bit n
- live_waveforms  in  NUM*2  channel n waveform at [2n+1:2n]
- wr_en  out  1  single-cycle memory write strobe
- wr_addr  out  $clog2(DEMO_SONG_LENGTH)  write address
- wr_data  out  96  encoded word
- busy  out  1  high in RECORD
- done  out  1  high in DONE
- rec_length  out  $clog2(DEMO_SONG_LENGTH)+1  words written this take

Behaviour:
- Reset (rst low, async): state IDLE; wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, rec_length=0, tick counter=0.
- FSM transitions:
  - IDLE --start--> RECORD. stop is ignored in IDLE; if start and stop are both high in IDLE, start wins.
  - RECORD --stop--> DONE. start is ignored in RECORD; if start and stop are both high in RECORD, stop wins.
  - RECORD --last word written--> DONE.
  - DONE --start--> RECORD (new take; rec_length is cleared).
- Entering RECORD clears the tick counter and address to 0.
- Tick counter counts 0..DEMO_CLK_DIVIDE-1 and wraps. While in RECORD, the cycle with counter==0 samples the live inputs.
- Registered outputs: wr_en, wr_data and wr_addr are driven the following cycle, with wr_en high for exactly one cycle. Writes are therefore DEMO_CLK_DIVIDE cycles apart, and the first wr_en occurs 2 cycles after start is sampled.
- After each write, the address increments and rec_length increments.
- The write at address DEMO_SONG_LENGTH-1 goes to DONE in the same cycle. wr_addr holds its last value.
- stop in the same cycle as a sample: that sample is discarded and no write is issued.
- Encoding, voice k = 0..5, base channel b = 4*(5-k):
  - wr_data[16k+15:16k+4] = pitch of channel b
  - wr_data[16k+1:16k] = waveform of channel b
  - vol code wr_data[16k+3:16k+2] from ena[b+3:b], priority order: bit3 set → 3; else bit1 → 2; else bit0 → 1; else 0.
  - Channel 24 is ignored.
- Reset mid-recording aborts immediately; no further writes.

Optional Feature:
- DEMO_ENCODER_LOOP_EN
  - Defined: after address DEMO_SONG_LENGTH-1 the address wraps to 0 and recording continues until stop. rec_length saturates at DEMO_SONG_LENGTH.
  - Undefined: the block stops at the last word (behaviour above).

Decomposition:
- Package demo_pkg holds:
  - constants DEMO_NUM_CH=25, DEMO_PITCH_W=12, DEMO_VOICES=6, DEMO_WORD_W=96
  - packed struct typedef demo_voice_t {pitch[11:0], vol[1:0], wave[1:0]}
  - enum typedef demo_enc_state_t {IDLE, RECORD, DONE}
  - function encode_vol(logic[3:0]) returning the 2-bit code
- One sub-module, demo_tick_gen: async active-low reset; tempo counter with synchronous clear and enable; outputs a 1-cycle tick.

Test Plan (DEMO_CLK_DIVIDE=4, DEMO_SONG_LENGTH=8):
- Reset: hold rst low mid-sim → all outputs 0 and state IDLE within the same cycle; no wr_en until the next start.
- Encode check: ch20 pitch 12'hABC, wave 2, ena[23:20]=4'b1111; ch0 pitch 12'h123, wave 1, ena[3:0]=4'b0011; start → first write at addr 0 with wr_data[15:0]=16'hABCE and wr_data[95:80]=16'h1239. Toggling ch24 has no effect on wr_data.
- Vol priority: ena group 4'b0001→code 1, 4'b0101→1, 4'b0110→2, 4'b1000→3, 4'b0000→0.
- Full take: start, no stop → 8 wr_en pulses, spaced 4 cycles apart, at addresses 0..7; done=1, busy=0, rec_length=8; no 9th write.
- Early stop: stop after the 3rd write → DONE, rec_length=3. stop coincident with a sample → that write is suppressed. Simultaneous start+stop in IDLE → recording begins.
- Loop (DEMO_ENCODER_LOOP_EN): 10 ticks then stop → addresses 0..7,0,1 written; rec_length=8.
